stream_shift_engine: RTL and testbench

STREAM_SHIFT_ENGINE -- requirements
Module: stream_shift_engine

---
 rtl/stream_shift_pkg.sv | 37 +++
 rtl/stream_shift_engine_shift_alu.sv | 36 +++
 rtl/stream_shift_engine.sv | 166 ++++++++++++++++
 tb/tb_stream_shift_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_shift_pkg.sv
// Shared definitions for the stream shift engine.
// Holds the opcode field values, the control state and shift-mode enums,
// and the default register-file addresses and completion code.
package stream_shift_pkg;

  // Opcode field values (top bits of each read-FIFO word)
  localparam logic [3:0] OP_SHR  = 4'b0001;
  localparam logic [3:0] OP_SHL  = 4'b0010;
  localparam logic [3:0] OP_ROR  = 4'b0011;
  localparam logic [3:0] OP_END  = 4'b0100;
  localparam logic [3:0] OP_DATA = 4'b1000;

  // Default register-file addresses and completion code
  localparam int          DEF_SHR_REG   = 2;
  localparam int          DEF_SHL_REG   = 3;
  localparam int          DEF_DONE_REG  = 4;
  localparam int          DEF_ROR_REG   = 5;
  localparam int          DEF_CNT_REG   = 6;
  localparam logic [31:0] DEF_DONE_CODE = 32'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_COUNT
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_SHR,
    MODE_SHL,
    MODE_ROR
  } mode_t;

endpackage

// File: rtl/stream_shift_engine_shift_alu.sv
// shift_alu: combinational payload transform.
// Ports:
//   mode    in  mode_t       PASS / SHR / SHL / ROR
//   amount  in  32           shift or rotate amount
//   payload in  PAY_W        data payload
//   result  out PAY_W        transformed payload
// Shifts by PAY_W or more clear the result; rotates use amount mod PAY_W.
module shift_alu
  import stream_shift_pkg::*;
#(
  parameter int PAY_W = 28
) (
  input  mode_t             mode,
  input  logic [31:0]       amount,
  input  logic [PAY_W-1:0]  payload,
  output logic [PAY_W-1:0]  result
);

  logic [31:0]        rot_amt;
  logic [2*PAY_W-1:0] doubled;

  // Rotating right is a right shift of the payload concatenated with itself;
  // the low PAY_W bits then hold the rotated word.
  always_comb begin
    rot_amt = amount % 32'(PAY_W);
    doubled = {payload, payload} >> rot_amt;
    result  = payload;
    case (mode)
      MODE_SHR: result = (amount >= 32'(PAY_W)) ? '0 : (payload >> amount);
      MODE_SHL: result = (amount >= 32'(PAY_W)) ? '0 : (payload << amount);
      MODE_ROR: result = doubled[PAY_W-1:0];
      default:  result = payload;
    endcase
  end

endmodule

// File: rtl/stream_shift_engine.sv
// stream_shift_engine: pops command/data words from a show-ahead read FIFO,
// transforms DATA payloads by the current shift mode, pushes results to a
// write FIFO, and on END reports a done code and the pushed-word count to a
// register file.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rdata, rdempty    read-FIFO head word and empty flag
//   rdack             pop read-FIFO head
//   wdata, wrreq      write-FIFO data and push
//   wrfull            write-FIFO full
//   u_addr, u_data    register-file address and combinational read data
//   u_write, u_wdata  register-file write enable and data
module stream_shift_engine
  import stream_shift_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          OP_W      = 4,
  parameter int          SHR_REG   = DEF_SHR_REG,
  parameter int          SHL_REG   = DEF_SHL_REG,
  parameter int          DONE_REG  = DEF_DONE_REG,
  parameter int          ROR_REG   = DEF_ROR_REG,
  parameter int          CNT_REG   = DEF_CNT_REG,
  parameter logic [31:0] DONE_CODE = DEF_DONE_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rdempty,
  output logic              rdack,
  output logic [DATA_W-1:0] wdata,
  output logic              wrreq,
  input  logic              wrfull,
  output logic [31:0]       u_addr,
  input  logic [31:0]       u_data,
  output logic              u_write,
  output logic [31:0]       u_wdata
);

  localparam int PAY_W = DATA_W - OP_W;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [31:0]       amount_q;
  logic [31:0]       count_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              load_out;
  logic              load_amount;
  logic              clear_run;
  logic [OP_W-1:0]   op;
  logic [PAY_W-1:0]  alu_result;

  assign op    = rdata[DATA_W-1 -: OP_W];
  assign wrreq = out_valid_q & ~wrfull;
  assign wdata = out_data_q;

  shift_alu #(.PAY_W(PAY_W)) u_alu (
    .mode    (mode_q),
    .amount  (amount_q),
    .payload (rdata[PAY_W-1:0]),
    .result  (alu_result)
  );

  // Register address of a mode's amount; PASS reads as the SHR register.
  function automatic logic [31:0] mode_reg(input mode_t m);
    case (m)
      MODE_SHL: mode_reg = 32'(SHL_REG);
      MODE_ROR: mode_reg = 32'(ROR_REG);
      default:  mode_reg = 32'(SHR_REG);
    endcase
  endfunction

  // Next-state and output decode. Mode words are always accepted; DATA waits
  // until the output register is free or draining this cycle. The mode is
  // committed at the pop so LOAD already addresses the new mode's register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rdack       = 1'b0;
    load_out    = 1'b0;
    load_amount = 1'b0;
    clear_run   = 1'b0;
    u_write     = 1'b0;
    u_wdata     = '0;
    u_addr      = mode_reg(mode_q);
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (!rdempty) begin
          case (op)
            OP_W'(OP_SHR): begin
              rdack = 1'b1; mode_d = MODE_SHR; state_d = ST_LOAD;
            end
            OP_W'(OP_SHL): begin
              rdack = 1'b1; mode_d = MODE_SHL; state_d = ST_LOAD;
            end
            OP_W'(OP_ROR): begin
              rdack = 1'b1; mode_d = MODE_ROR; state_d = ST_LOAD;
            end
            OP_W'(OP_DATA): begin
              if (!out_valid_q || wrreq) begin
                rdack    = 1'b1;
                load_out = 1'b1;
              end
            end
            OP_W'(OP_END): begin
              rdack = 1'b1; state_d = ST_DRAIN;
            end
            default: rdack = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        load_amount = 1'b1;
        state_d     = ST_RUN;
      end
      ST_DRAIN: begin
        if (!out_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        u_write = 1'b1;
        u_addr  = 32'(DONE_REG);
        u_wdata = DONE_CODE;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        u_write   = 1'b1;
        u_addr    = 32'(CNT_REG);
        u_wdata   = count_q;
        clear_run = 1'b1;
        mode_d    = MODE_PASS;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, mode, amount, saturating push count and the one-word output
  // register. A new word replaces the held one in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_PASS;
      amount_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      if (clear_run) begin
        amount_q <= '0;
        count_q  <= '0;
      end else begin
        if (load_amount) amount_q <= u_data;
        if (wrreq && (count_q != 32'hFFFF_FFFF)) count_q <= count_q + 32'd1;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {{OP_W{1'b0}}, alu_result};
      end else if (wrreq) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_shift_engine.sv
// Directed bench for stream_shift_engine: models the read FIFO, the register
// file and logs every push and register write, then checks each scenario
// against hand-computed results.
module tb_stream_shift_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rdata;
  logic        rdempty;
  logic        rdack;
  logic [31:0] wdata;
  logic        wrreq;
  logic        wrfull;
  logic [31:0] u_addr;
  logic [31:0] u_data;
  logic        u_write;
  logic [31:0] u_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] in_mem [0:63];
  int          in_wr;
  int          in_rd = 0;
  logic [31:0] regs [0:15];

  logic [31:0] push_log [0:63];
  logic [31:0] wa_log   [0:63];
  logic [31:0] wd_log   [0:63];
  int          push_n = 0;
  int          wr_n   = 0;

  always #5 clk = ~clk;

  stream_shift_engine dut (
    .clk     (clk),
    .reset   (reset),
    .rdata   (rdata),
    .rdempty (rdempty),
    .rdack   (rdack),
    .wdata   (wdata),
    .wrreq   (wrreq),
    .wrfull  (wrfull),
    .u_addr  (u_addr),
    .u_data  (u_data),
    .u_write (u_write),
    .u_wdata (u_wdata)
  );

  assign rdata   = in_mem[in_rd[5:0]];
  assign rdempty = (in_rd == in_wr);
  assign u_data  = regs[u_addr[3:0]];

  // Read-FIFO pop and logging of pushes / register writes at the clock edge
  always @(posedge clk) begin
    if (rdack) in_rd <= in_rd + 1;
    if (!reset && wrreq && push_n < 64) begin
      push_log[push_n] <= wdata;
      push_n <= push_n + 1;
    end
    if (!reset && u_write && wr_n < 64) begin
      wa_log[wr_n] <= u_addr;
      wd_log[wr_n] <= u_wdata;
      wr_n <= wr_n + 1;
    end
  end

  task automatic push_word(input logic [31:0] w);
    in_mem[in_wr[5:0]] = w;
    in_wr = in_wr + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rdack !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdack got=%0b want=0", rdack); end
    total++; if (wrreq !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrreq got=%0b want=0", wrreq); end
    total++; if (u_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_u_write got=%0b want=0", u_write); end
    total++; if (wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", wdata); end
    total++; if (u_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_u_wdata got=%h want=0", u_wdata); end
    total++; if (u_addr !== 32'd2) begin bad++; $display("[TB] FAIL reset_u_addr got=%0d want=2", u_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shr();
    int pb, wb;
    pb = push_n; wb = wr_n;
    regs[2] = 32'd4;
    push_word(32'h1000_0000);
    push_word(32'h8000_00F0);
    push_word(32'h4000_0000);
    repeat (20) @(negedge clk);
    total++; if (push_n - pb !== 1) begin bad++; $display("[TB] FAIL shr_push_count got=%0d want=1", push_n - pb); end
    total++; if (push_log[pb] !== 32'h0000_000F) begin bad++; $display("[TB] FAIL shr_data got=%h want=0000000f", push_log[pb]); end
    total++; if (wr_n - wb !== 2) begin bad++; $display("[TB] FAIL shr_write_count got=%0d want=2", wr_n - wb); end
    total++; if (wa_log[wb] !== 32'd4 || wd_log[wb] !== 32'h0000_FFFF) begin bad++; $display("[TB] FAIL shr_done_write got=(%0d,%h) want=(4,0000ffff)", wa_log[wb], wd_log[wb]); end
    total++; if (wa_log[wb+1] !== 32'd6 || wd_log[wb+1] !== 32'd1) begin bad++; $display("[TB] FAIL shr_count_write got=(%0d,%h) want=(6,1)", wa_log[wb+1], wd_log[wb+1]); end
    total++; if (u_addr !== 32'd2) begin bad++; $display("[TB] FAIL shr_idle_addr got=%0d want=2", u_addr); end
  endtask

  task automatic test_shl();
    int pb, wb;
    pb = push_n; wb = wr_n;
    regs[3] = 32'd8;
    push_word(32'h2000_0000);
    push_word(32'h8000_0012);
    push_word(32'h8FFF_FFFF);
    push_word(32'h4000_0000);
    repeat (20) @(negedge clk);
    total++; if (push_n - pb !== 2) begin bad++; $display("[TB] FAIL shl_push_count got=%0d want=2", push_n - pb); end
    total++; if (push_log[pb] !== 32'h0000_1200) begin bad++; $display("[TB] FAIL shl_data0 got=%h want=00001200", push_log[pb]); end
    total++; if (push_log[pb+1] !== 32'h0FFF_FF00) begin bad++; $display("[TB] FAIL shl_data1 got=%h want=0fffff00", push_log[pb+1]); end
    total++; if (wd_log[wb+1] !== 32'd2) begin bad++; $display("[TB] FAIL shl_count got=%0d want=2", wd_log[wb+1]); end
  endtask

  task automatic test_ror_and_bounds();
    int pb, wb;
    pb = push_n; wb = wr_n;
    regs[5] = 32'd4;
    push_word(32'h3000_0000);
    push_word(32'h8000_0001);
    repeat (8) @(negedge clk);
    regs[5] = 32'd30;
    push_word(32'h3000_0000);
    push_word(32'h5000_0000);
    push_word(32'h8000_0001);
    repeat (8) @(negedge clk);
    regs[2] = 32'd40;
    push_word(32'h1000_0000);
    push_word(32'h8FFF_FFFF);
    push_word(32'h4000_0000);
    repeat (20) @(negedge clk);
    total++; if (push_n - pb !== 3) begin bad++; $display("[TB] FAIL ror_push_count got=%0d want=3", push_n - pb); end
    total++; if (push_log[pb] !== 32'h0100_0000) begin bad++; $display("[TB] FAIL ror4 got=%h want=01000000", push_log[pb]); end
    total++; if (push_log[pb+1] !== 32'h0400_0000) begin bad++; $display("[TB] FAIL ror30 got=%h want=04000000", push_log[pb+1]); end
    total++; if (push_log[pb+2] !== 32'h0000_0000) begin bad++; $display("[TB] FAIL shr40 got=%h want=00000000", push_log[pb+2]); end
    total++; if (wd_log[wb+1] !== 32'd3) begin bad++; $display("[TB] FAIL ror_count got=%0d want=3", wd_log[wb+1]); end
  endtask

  task automatic test_pass();
    int pb, wb;
    pb = push_n; wb = wr_n;
    push_word(32'h8123_4567);
    push_word(32'h4000_0000);
    repeat (15) @(negedge clk);
    total++; if (push_n - pb !== 1 || push_log[pb] !== 32'h0123_4567) begin bad++; $display("[TB] FAIL pass_data got=%h n=%0d want=01234567 n=1", push_log[pb], push_n - pb); end
    total++; if (wd_log[wb+1] !== 32'd1) begin bad++; $display("[TB] FAIL pass_count got=%0d want=1", wd_log[wb+1]); end
  endtask

  task automatic test_back_to_back();
    int pb, wb, rb;
    pb = push_n; wb = wr_n; rb = in_rd;
    regs[2] = 32'd0;
    wrfull = 1'b1;
    push_word(32'h1000_0000);
    push_word(32'h8000_000A);
    push_word(32'h8000_000B);
    push_word(32'h8000_000C);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wrreq !== 1'b0 || wdata !== 32'h0000_000A) begin
        bad++; $display("[TB] FAIL stall_hold cyc=%0d got wrreq=%0b wdata=%h want wrreq=0 wdata=0000000a", i, wrreq, wdata);
      end
      @(negedge clk);
    end
    total++; if (in_rd - rb !== 2) begin bad++; $display("[TB] FAIL stall_pops got=%0d want=2", in_rd - rb); end
    wrfull = 1'b0;
    push_word(32'h4000_0000);
    repeat (20) @(negedge clk);
    total++; if (push_n - pb !== 3) begin bad++; $display("[TB] FAIL stall_push_count got=%0d want=3", push_n - pb); end
    total++; if (push_log[pb] !== 32'hA || push_log[pb+1] !== 32'hB || push_log[pb+2] !== 32'hC) begin
      bad++; $display("[TB] FAIL stall_order got=%h,%h,%h want=a,b,c", push_log[pb], push_log[pb+1], push_log[pb+2]);
    end
    total++; if (wd_log[wb+1] !== 32'd3) begin bad++; $display("[TB] FAIL stall_count got=%0d want=3", wd_log[wb+1]); end
  endtask

  task automatic test_reset_in_drain();
    int pb, wb;
    pb = push_n; wb = wr_n;
    wrfull = 1'b1;
    push_word(32'h1000_0000);
    push_word(32'h8000_0007);
    push_word(32'h4000_0000);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wrfull = 1'b0;
    total++; if (wrreq !== 1'b0 || wdata !== 32'h0) begin bad++; $display("[TB] FAIL drain_reset_out got wrreq=%0b wdata=%h want 0,0", wrreq, wdata); end
    repeat (10) @(negedge clk);
    total++; if (push_n !== pb || wr_n !== wb) begin bad++; $display("[TB] FAIL drain_reset_quiet got pushes=%0d writes=%0d want 0,0", push_n - pb, wr_n - wb); end
    push_word(32'h8000_0009);
    push_word(32'h4000_0000);
    repeat (15) @(negedge clk);
    total++; if (push_n - pb !== 1 || push_log[pb] !== 32'h9) begin bad++; $display("[TB] FAIL drain_after_data got=%h n=%0d want=00000009 n=1", push_log[pb], push_n - pb); end
    total++; if (wr_n - wb !== 2 || wd_log[wb+1] !== 32'd1) begin bad++; $display("[TB] FAIL drain_after_count got=%0d n=%0d want=1 n=2", wd_log[wb+1], wr_n - wb); end
  endtask

  initial begin
    reset  = 1'b1;
    wrfull = 1'b0;
    in_wr  = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    for (int i = 0; i < 64; i++) in_mem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_shr();
    test_shl();
    test_ror_and_bounds();
    test_pass();
    test_back_to_back();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
